mem_arbiter: RTL and testbench

- Shares one single-ported synchronous SRAM between the instruction-fetch port and the data (mem-stage) port of the core, so a single unified memory can replace the separate imem/dmem.
- Performs one access per cycle and gives data priority, because the data access belongs to the older instruction.
- Bounds fetch starvation with a counter.
- Supports a locked read-modify-write sequence on the data port.
- Returns read data one cycle after each grant.

---
 rtl/mem_arbiter.sv | 118 +++++++++++
 tb/tb_mem_arbiter.sv | 382 ++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/mem_arbiter.sv
// Shares one single-ported synchronous SRAM between instruction fetch and the data port.
// Data has priority, fetch starvation is bounded, and the data port can lock the memory.
module mem_arbiter #(
   parameter int ADDR_WIDTH   = 16,
   parameter int DATA_WIDTH   = 32,
   parameter int STARVE_LIMIT = 4
) (
   input  logic                      clk,
   input  logic                      reset,
   input  logic                      if_req,
   input  logic [ADDR_WIDTH-1:0]     if_addr,
   output logic                      if_gnt,
   output logic                      if_rvalid,
   output logic [DATA_WIDTH-1:0]     if_rdata,
   input  logic                      d_req,
   input  logic [ADDR_WIDTH-1:0]     d_addr,
   input  logic [DATA_WIDTH/8-1:0]   d_we,
   input  logic [DATA_WIDTH-1:0]     d_wdata,
   input  logic                      d_lock,
   output logic                      d_gnt,
   output logic                      d_rvalid,
   output logic [DATA_WIDTH-1:0]     d_rdata,
   output logic                      mem_en,
   output logic [ADDR_WIDTH-1:0]     mem_addr,
   output logic [DATA_WIDTH/8-1:0]   mem_we,
   output logic [DATA_WIDTH-1:0]     mem_wdata,
   input  logic [DATA_WIDTH-1:0]     mem_rdata
);

   localparam logic [3:0] LIMIT = 4'(STARVE_LIMIT);

   typedef enum logic [1:0] {
      SRC_NONE = 2'd0,
      SRC_IF   = 2'd1,
      SRC_D    = 2'd2
   } src_e;

   src_e       pend_src_q, pend_src_d;
   logic       lock_q, lock_d;
   logic [3:0] starve_cnt_q, starve_cnt_d;

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         pend_src_q   <= SRC_NONE;
         lock_q       <= 1'b0;
         starve_cnt_q <= 4'd0;
      end else begin
         pend_src_q   <= pend_src_d;
         lock_q       <= lock_d;
         starve_cnt_q <= starve_cnt_d;
      end
   end

   // Grants are gated by reset itself so nothing is accepted while reset is held.
   always_comb begin
      if_gnt = 1'b0;
      d_gnt  = 1'b0;
      if (!reset) begin
         if (lock_q) begin
            d_gnt = d_req;
         end else if (if_req && d_req) begin
            if (starve_cnt_q == LIMIT) begin
               if_gnt = 1'b1;
            end else begin
               d_gnt = 1'b1;
            end
         end else begin
            if_gnt = if_req;
            d_gnt  = d_req;
         end
      end
   end

   always_comb begin
      mem_en    = if_gnt | d_gnt;
      mem_addr  = '0;
      mem_we    = '0;
      mem_wdata = '0;
      if (if_gnt) begin
         mem_addr = if_addr;
      end else if (d_gnt) begin
         mem_addr  = d_addr;
         mem_we    = d_we;
         mem_wdata = d_wdata;
      end
   end

   // The counter only tracks data grants that actually held fetch off in open arbitration.
   always_comb begin
      starve_cnt_d = starve_cnt_q;
      lock_d       = lock_q;
      pend_src_d   = SRC_NONE;

      if (!if_req || if_gnt) begin
         starve_cnt_d = 4'd0;
      end else if (d_gnt && !lock_q && (starve_cnt_q < LIMIT)) begin
         starve_cnt_d = starve_cnt_q + 4'd1;
      end

      if (d_gnt) begin
         lock_d = d_lock;
      end

      if (if_gnt) begin
         pend_src_d = SRC_IF;
      end else if (d_gnt) begin
         pend_src_d = SRC_D;
      end
   end

   always_comb begin
      if_rvalid = (pend_src_q == SRC_IF);
      d_rvalid  = (pend_src_q == SRC_D);
      if_rdata  = if_rvalid ? mem_rdata : '0;
      d_rdata   = d_rvalid  ? mem_rdata : '0;
   end

endmodule

// File: tb/tb_mem_arbiter.sv
// Self-checking bench for mem_arbiter: directed scenarios plus randomized traffic
// compared against a rule-level reference model and a separate reference memory.
module tb_mem_arbiter;

   localparam int AW    = 16;
   localparam int DW    = 32;
   localparam int BW    = DW / 8;
   localparam int LIMIT = 4;

   logic          clk = 1'b0;
   logic          reset;
   logic          if_req;
   logic [AW-1:0] if_addr;
   logic          if_gnt;
   logic          if_rvalid;
   logic [DW-1:0] if_rdata;
   logic          d_req;
   logic [AW-1:0] d_addr;
   logic [BW-1:0] d_we;
   logic [DW-1:0] d_wdata;
   logic          d_lock;
   logic          d_gnt;
   logic          d_rvalid;
   logic [DW-1:0] d_rdata;
   logic          mem_en;
   logic [AW-1:0] mem_addr;
   logic [BW-1:0] mem_we;
   logic [DW-1:0] mem_wdata;
   logic [DW-1:0] mem_rdata = '0;

   always #5 clk = ~clk;

   mem_arbiter #(
      .ADDR_WIDTH  (AW),
      .DATA_WIDTH  (DW),
      .STARVE_LIMIT(LIMIT)
   ) dut (
      .clk      (clk),
      .reset    (reset),
      .if_req   (if_req),
      .if_addr  (if_addr),
      .if_gnt   (if_gnt),
      .if_rvalid(if_rvalid),
      .if_rdata (if_rdata),
      .d_req    (d_req),
      .d_addr   (d_addr),
      .d_we     (d_we),
      .d_wdata  (d_wdata),
      .d_lock   (d_lock),
      .d_gnt    (d_gnt),
      .d_rvalid (d_rvalid),
      .d_rdata  (d_rdata),
      .mem_en   (mem_en),
      .mem_addr (mem_addr),
      .mem_we   (mem_we),
      .mem_wdata(mem_wdata),
      .mem_rdata(mem_rdata)
   );

   // SRAM environment model, read-first, driven only by the DUT's memory port.
   logic [DW-1:0] sram    [0:16383];
   logic [DW-1:0] ref_mem [0:16383];

   always @(posedge clk) begin
      if (mem_en) begin
         mem_rdata <= sram[mem_addr[15:2]];
         for (int b = 0; b < BW; b++) begin
            if (mem_we[b]) sram[mem_addr[15:2]][b*8 +: 8] <= mem_wdata[b*8 +: 8];
         end
      end
   end

   int errors = 0;
   int checks = 0;

   // Reference model state
   bit            m_lock;
   int            m_starve;
   int            m_pend;       // 0 none, 1 fetch, 2 data
   logic [DW-1:0] m_pend_data;

   // Expected combinational outputs for the current cycle
   bit            e_if, e_d;
   logic [AW-1:0] e_addr;
   logic [BW-1:0] e_we;
   logic [DW-1:0] e_wdata;

   task automatic model_eval();
      e_if = 1'b0;
      e_d  = 1'b0;
      if (!reset) begin
         if (m_lock) e_d = d_req;
         else if (if_req && d_req) begin
            if (m_starve >= LIMIT) e_if = 1'b1;
            else e_d = 1'b1;
         end else begin
            e_if = if_req;
            e_d  = d_req;
         end
      end
      e_addr  = e_if ? if_addr : (e_d ? d_addr : '0);
      e_we    = e_d ? d_we : '0;
      e_wdata = e_d ? d_wdata : '0;
   endtask

   task automatic model_commit();
      int w;
      if (reset) return;
      if (!if_req || e_if) m_starve = 0;
      else if (e_d && !m_lock && m_starve < LIMIT) m_starve = m_starve + 1;
      if (e_d) m_lock = d_lock;
      m_pend = e_if ? 1 : (e_d ? 2 : 0);
      if (e_if || e_d) begin
         w = int'(e_addr[15:2]);
         m_pend_data = ref_mem[w];
         for (int b = 0; b < BW; b++) begin
            if (e_we[b]) ref_mem[w][b*8 +: 8] = e_wdata[b*8 +: 8];
         end
      end
   endtask

   task automatic settle();
      @(negedge clk);
      model_eval();
   endtask

   task automatic tick();
      model_commit();
      @(posedge clk);
      #1;
   endtask

   task automatic model_reset();
      m_lock   = 1'b0;
      m_starve = 0;
      m_pend   = 0;
   endtask

   task automatic drive_idle();
      if_req  = 1'b0;
      if_addr = '0;
      d_req   = 1'b0;
      d_addr  = '0;
      d_we    = '0;
      d_wdata = '0;
      d_lock  = 1'b0;
   endtask

   task automatic test_reset();
      drive_idle();
      if_req = 1'b1; if_addr = 16'h0010;
      d_req  = 1'b1; d_addr  = 16'h0020; d_we = 4'hF; d_wdata = 32'h12345678;
      reset = 1'b1;
      model_reset();
      #2;
      checks++; if (if_gnt !== 1'b0) begin errors++; $display("FAIL reset_if_gnt got=%b exp=0", if_gnt); end
      checks++; if (d_gnt !== 1'b0) begin errors++; $display("FAIL reset_d_gnt got=%b exp=0", d_gnt); end
      checks++; if (mem_en !== 1'b0) begin errors++; $display("FAIL reset_mem_en got=%b exp=0", mem_en); end
      checks++; if ({mem_addr, mem_we, mem_wdata} !== '0) begin errors++; $display("FAIL reset_mem_bus got addr=%h we=%h wdata=%h exp=0", mem_addr, mem_we, mem_wdata); end
      checks++; if ({if_rvalid, d_rvalid} !== 2'b00) begin errors++; $display("FAIL reset_rvalid got if=%b d=%b exp=0", if_rvalid, d_rvalid); end
      checks++; if ({if_rdata, d_rdata} !== '0) begin errors++; $display("FAIL reset_rdata got if=%h d=%h exp=0", if_rdata, d_rdata); end
      repeat (2) @(posedge clk);
      #1;
      drive_idle();
      reset = 1'b0;
   endtask

   task automatic test_fetch();
      sram[1] = 32'h00A00093;
      ref_mem[1] = 32'h00A00093;
      drive_idle();
      if_req = 1'b1; if_addr = 16'h0004;
      settle();
      checks++; if (if_gnt !== 1'b1 || d_gnt !== 1'b0) begin errors++; $display("FAIL fetch_gnt got if=%b d=%b exp if=1 d=0", if_gnt, d_gnt); end
      checks++; if (mem_en !== 1'b1 || mem_addr !== 16'h0004 || mem_we !== 4'h0) begin errors++; $display("FAIL fetch_mem got en=%b addr=%h we=%h exp en=1 addr=0004 we=0", mem_en, mem_addr, mem_we); end
      tick();
      $display("txn fetch addr=0004");
      if_req = 1'b0;
      settle();
      checks++; if (if_rvalid !== 1'b1 || if_rdata !== 32'h00A00093) begin errors++; $display("FAIL fetch_rdata got v=%b data=%h exp v=1 data=00a00093", if_rvalid, if_rdata); end
      checks++; if (d_rvalid !== 1'b0) begin errors++; $display("FAIL fetch_d_rvalid got=%b exp=0", d_rvalid); end
      tick();
   endtask

   task automatic test_write_read();
      drive_idle();
      d_req = 1'b1; d_addr = 16'h0100; d_we = 4'hF; d_wdata = 32'hDEADBEEF;
      settle();
      checks++; if (d_gnt !== 1'b1 || mem_we !== 4'hF || mem_wdata !== 32'hDEADBEEF || mem_addr !== 16'h0100) begin
         errors++; $display("FAIL wr_mem got gnt=%b addr=%h we=%h wdata=%h exp gnt=1 addr=0100 we=f wdata=deadbeef", d_gnt, mem_addr, mem_we, mem_wdata); end
      tick();
      $display("txn data write addr=0100 data=deadbeef");
      d_we = 4'h0; d_wdata = '0;
      settle();
      checks++; if (d_rvalid !== 1'b1 || if_rvalid !== 1'b0) begin errors++; $display("FAIL wr_rvalid got d=%b if=%b exp d=1 if=0", d_rvalid, if_rvalid); end
      checks++; if (d_gnt !== 1'b1 || mem_we !== 4'h0 || mem_wdata !== '0) begin errors++; $display("FAIL rd_mem got gnt=%b we=%h wdata=%h exp gnt=1 we=0 wdata=0", d_gnt, mem_we, mem_wdata); end
      tick();
      $display("txn data read addr=0100");
      d_req = 1'b0;
      settle();
      checks++; if (d_rvalid !== 1'b1 || d_rdata !== 32'hDEADBEEF) begin errors++; $display("FAIL rd_data got v=%b data=%h exp v=1 data=deadbeef", d_rvalid, d_rdata); end
      tick();
   endtask

   task automatic test_byte_write();
      drive_idle();
      d_req = 1'b1; d_addr = 16'h0140; d_we = 4'hF; d_wdata = 32'h11223344;
      settle(); tick();
      d_we = 4'b0010; d_wdata = 32'h0000AB00;
      settle();
      checks++; if (mem_we !== 4'b0010 || mem_wdata !== 32'h0000AB00) begin errors++; $display("FAIL byte_mem got we=%h wdata=%h exp we=2 wdata=0000ab00", mem_we, mem_wdata); end
      tick();
      d_we = 4'h0; d_wdata = '0;
      settle(); tick();
      d_req = 1'b0;
      settle();
      checks++; if (d_rvalid !== 1'b1 || d_rdata !== 32'h1122AB44) begin errors++; $display("FAIL byte_readback got v=%b data=%h exp v=1 data=1122ab44", d_rvalid, d_rdata); end
      $display("txn byte write/readback addr=0140 data=%h", d_rdata);
      tick();
   endtask

   task automatic test_collision();
      bit exp_if, prev_if;
      drive_idle();
      if_req = 1'b1; if_addr = 16'h0008;
      d_req  = 1'b1; d_addr  = 16'h0100;
      prev_if = 1'b0;
      for (int i = 0; i < 15; i++) begin
         exp_if = ((i % (LIMIT + 1)) == LIMIT);
         settle();
         checks++; if (if_gnt !== exp_if || d_gnt !== !exp_if) begin
            errors++; $display("FAIL collision_gnt[%0d] got if=%b d=%b exp if=%b d=%b", i, if_gnt, d_gnt, exp_if, !exp_if); end
         if (i > 0) begin
            checks++; if (if_rvalid !== prev_if || d_rvalid !== !prev_if) begin
               errors++; $display("FAIL collision_rvalid[%0d] got if=%b d=%b exp if=%b d=%b", i, if_rvalid, d_rvalid, prev_if, !prev_if); end
         end
         $display("txn collision cycle %0d grant=%s", i, exp_if ? "IF" : "D");
         prev_if = exp_if;
         tick();
      end
      drive_idle();
      settle(); tick();
   endtask

   task automatic test_lock();
      // cycle -> {d_req, d_lock, write}
      logic [2:0] tab [0:7];
      tab[0] = 3'b110; tab[1] = 3'b000; tab[2] = 3'b000; tab[3] = 3'b110;
      tab[4] = 3'b110; tab[5] = 3'b110; tab[6] = 3'b110; tab[7] = 3'b101;
      drive_idle();
      if_req = 1'b1; if_addr = 16'h000C;
      d_addr = 16'h0200;
      for (int i = 0; i < 8; i++) begin
         d_req   = tab[i][2];
         d_lock  = tab[i][1];
         d_we    = tab[i][0] ? 4'h1 : 4'h0;
         d_wdata = tab[i][0] ? 32'h000000C3 : 32'h0;
         settle();
         checks++; if (if_gnt !== 1'b0 || d_gnt !== tab[i][2]) begin
            errors++; $display("FAIL lock_gnt[%0d] got if=%b d=%b exp if=0 d=%b", i, if_gnt, d_gnt, tab[i][2]); end
         tick();
      end
      drive_idle();
      if_req = 1'b1; if_addr = 16'h000C;
      settle();
      checks++; if (if_gnt !== 1'b1) begin errors++; $display("FAIL unlock_if_gnt got=%b exp=1", if_gnt); end
      $display("txn lock sequence done, fetch granted after unlock");
      tick();
      drive_idle();
      settle(); tick();
   endtask

   task automatic test_reset_mid();
      drive_idle();
      if_req = 1'b1; if_addr = 16'h0004;
      settle();
      checks++; if (if_gnt !== 1'b1) begin errors++; $display("FAIL rmid_pre_gnt got=%b exp=1", if_gnt); end
      tick();
      reset = 1'b1;
      model_reset();
      #1;
      checks++; if (if_rvalid !== 1'b0 || if_rdata !== '0) begin errors++; $display("FAIL rmid_rvalid_drop got v=%b data=%h exp v=0 data=0", if_rvalid, if_rdata); end
      repeat (2) @(posedge clk);
      #1;
      reset = 1'b0;
      settle();
      checks++; if (if_gnt !== 1'b1) begin errors++; $display("FAIL rmid_first_gnt got=%b exp=1", if_gnt); end
      tick();
      if_req = 1'b0;
      settle();
      checks++; if (if_rvalid !== 1'b1 || if_rdata !== 32'h00A00093) begin errors++; $display("FAIL rmid_refetch got v=%b data=%h exp v=1 data=00a00093", if_rvalid, if_rdata); end
      tick();

      // A lock held at reset must not survive it.
      d_req = 1'b1; d_lock = 1'b1; d_addr = 16'h0200;
      settle(); tick();
      drive_idle();
      reset = 1'b1;
      model_reset();
      repeat (2) @(posedge clk);
      #1;
      reset = 1'b0;
      if_req = 1'b1; if_addr = 16'h0004;
      settle();
      checks++; if (if_gnt !== 1'b1) begin errors++; $display("FAIL rmid_lock_cleared got if_gnt=%b exp=1", if_gnt); end
      tick();
      drive_idle();
      settle(); tick();
      $display("txn reset mid-access sequence done");
   endtask

   task automatic test_random();
      for (int n = 0; n < 600; n++) begin
         if (!if_req || e_if) begin
            if ($urandom_range(0, 3) != 0) begin
               if_req  = 1'b1;
               if_addr = {9'd0, 5'($urandom), 2'b00};
            end else begin
               if_req = 1'b0;
            end
         end
         if (!d_req || e_d) begin
            if ($urandom_range(0, 2) != 0) begin
               d_req   = 1'b1;
               d_addr  = {9'd0, 5'($urandom), 2'b00};
               d_we    = ($urandom_range(0, 1) == 1) ? 4'($urandom) : 4'h0;
               d_wdata = $urandom;
               d_lock  = ($urandom_range(0, 7) == 0);
            end else begin
               d_req  = 1'b0;
               d_lock = 1'b0;
            end
         end
         settle();
         checks++; if (if_gnt !== e_if || d_gnt !== e_d) begin
            errors++; $display("FAIL rnd_gnt[%0d] got if=%b d=%b exp if=%b d=%b", n, if_gnt, d_gnt, e_if, e_d); end
         checks++; if (mem_en !== (e_if | e_d) || mem_addr !== e_addr || mem_we !== e_we || mem_wdata !== e_wdata) begin
            errors++; $display("FAIL rnd_mem[%0d] got en=%b addr=%h we=%h wdata=%h exp en=%b addr=%h we=%h wdata=%h",
                               n, mem_en, mem_addr, mem_we, mem_wdata, e_if | e_d, e_addr, e_we, e_wdata); end
         checks++; if (if_rvalid !== (m_pend == 1) || d_rvalid !== (m_pend == 2)) begin
            errors++; $display("FAIL rnd_rvalid[%0d] got if=%b d=%b exp if=%b d=%b", n, if_rvalid, d_rvalid, m_pend == 1, m_pend == 2); end
         checks++; if (if_rdata !== ((m_pend == 1) ? m_pend_data : '0) || d_rdata !== ((m_pend == 2) ? m_pend_data : '0)) begin
            errors++; $display("FAIL rnd_rdata[%0d] got if=%h d=%h exp data=%h src=%0d", n, if_rdata, d_rdata, m_pend_data, m_pend); end
         if (e_if) $display("txn rnd %0d IF addr=%h", n, if_addr);
         else if (e_d) $display("txn rnd %0d D addr=%h we=%h wdata=%h lock=%b", n, d_addr, d_we, d_wdata, d_lock);
         tick();
      end
      drive_idle();
      settle(); tick();
   endtask

   initial begin
      #2000000;
      $display("FAIL watchdog simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      for (int i = 0; i < 16384; i++) begin
         sram[i]    = 32'(i) * 32'h01010101 ^ 32'hA5A50000;
         ref_mem[i] = 32'(i) * 32'h01010101 ^ 32'hA5A50000;
      end
      e_if = 1'b0;
      e_d  = 1'b0;
      m_pend_data = '0;
      reset = 1'b0;
      drive_idle();
      @(posedge clk);
      #1;
      test_reset();
      test_fetch();
      test_write_read();
      test_byte_write();
      test_collision();
      test_lock();
      test_reset_mid();
      test_random();
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
